gray_rx_decoder: RTL and testbench

Receive-side companion to the team's N-bit Gray counter. Samples a Gray-coded count that may come from another clock domain, synchronizes it, converts it to binary and tracks it cycle by cycle. Reports each single step up or down and counter wrap-around. Flags any illegal transition (not ±1) and counts such errors. Sits at the consumer end of any Gray-coded pointer or position bus.

---
 rtl/gray_rx_decoder.sv | 157 +++++++++++++++
 tb/tb_gray_rx_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: synchronizes a Gray-coded count, decodes it to binary
// and reports +1/-1 steps, wrap-around and illegal jumps.
module gray_rx_decoder #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] bin_out,
    output logic         valid,
    output logic         step_up,
    output logic         step_down,
    output logic         wrap,
    output logic         err,
    output logic [7:0]   err_count
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(SYNC_STAGES - 1);
    localparam logic [N-1:0]  BIN_ONE   = N'(1);
    localparam logic [N-1:0]  BIN_MAX   = '1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  sync_d [SYNC_STAGES];
    logic [N-1:0]  bin_out_q, bin_out_d;
    logic          valid_q, valid_d;
    logic          step_up_q, step_up_d;
    logic          step_down_q, step_down_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic [7:0]    err_count_q, err_count_d;

    logic [N-1:0]  g_sync;
    logic [N-1:0]  bin_cur;
    logic [N-1:0]  bin_inc;
    logic [N-1:0]  bin_dec;

    // Synchronizer chain: shift gray_in toward g_sync one stage per edge
    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign g_sync = sync_q[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the parity of the Gray bits at and above it
    always_comb begin
        bin_cur = '0;
        for (int i = 0; i < N; i++) begin
            bin_cur[i] = ^(g_sync >> i);
        end
    end

    assign bin_inc = bin_out_q + BIN_ONE;
    assign bin_dec = bin_out_q - BIN_ONE;

    // Next-state and output logic: fill, acquire once, then classify every edge
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        bin_out_d   = bin_out_q;
        valid_d     = valid_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        wrap_d      = 1'b0;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        unique case (state_q)
            FILL: begin
                fill_cnt_d = fill_cnt_q + CW'(1);
                if (fill_cnt_q == FILL_LAST) begin
                    fill_cnt_d = '0;
                    state_d    = ACQ;
                end
            end
            ACQ: begin
                bin_out_d = bin_cur;
                valid_d   = 1'b1;
                state_d   = TRACK;
            end
            TRACK: begin
                if (bin_cur == bin_out_q) begin
                    bin_out_d = bin_out_q;
                end else if (bin_cur == bin_inc) begin
                    bin_out_d = bin_cur;
                    step_up_d = 1'b1;
                    wrap_d    = (bin_out_q == BIN_MAX);
                end else if (bin_cur == bin_dec) begin
                    bin_out_d   = bin_cur;
                    step_down_d = 1'b1;
                    wrap_d      = (bin_out_q == '0);
                end else begin
                    // Illegal jump: flag it and resynchronize to the new value
                    bin_out_d = bin_cur;
                    err_d     = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers, all cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            bin_out_q   <= '0;
            valid_q     <= 1'b0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            bin_out_q   <= bin_out_d;
            valid_q     <= valid_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign valid     = valid_q;
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign wrap      = wrap_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder: directed and randomized Gray sequences checked against
// a transaction-level model of the decoder.
module tb_gray_rx_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic       valid;
    logic       step_up;
    logic       step_down;
    logic       wrap;
    logic       err;
    logic [7:0] err_count;

    int n_checks;
    int n_errors;

    // Model state: last accepted binary value and error count
    int m_bin;
    int m_errc;

    gray_rx_decoder #(.N(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .valid     (valid),
        .step_up   (step_up),
        .step_down (step_down),
        .wrap      (wrap),
        .err       (err),
        .err_count (err_count)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] b2g(input int b);
        int x;
        x = b & 15;
        return 4'(x ^ (x >> 1));
    endfunction

    // Inverse by search over all codes, independent of any bitwise decode
    function automatic int g2b(input logic [3:0] g);
        for (int i = 0; i < 16; i++) begin
            if (b2g(i) == g) return i;
        end
        return -1;
    endfunction

    task automatic chk_all(input string tag, input logic v, input int b,
                           input logic [3:0] pulses, input int ec);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".bin"}, 32'(bin_out), 32'(b));
        chk({tag, ".pulses"}, 32'({step_up, step_down, wrap, err}),
            32'(pulses));
        chk({tag, ".errc"}, 32'(err_count), 32'(ec));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with gray_in held at g, then verify acquisition on edge 3
    task automatic acquire(input string tag, input logic [3:0] g);
        reset   = 1'b1;
        gray_in = g;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e < 3) chk_all({tag, ".fill"}, 1'b0, 0, 4'b0, 0);
            else       chk_all({tag, ".acq"}, 1'b1, g2b(g), 4'b0, 0);
        end
        m_bin  = g2b(g);
        m_errc = 0;
    endtask

    // Apply one gray_in change and check the 4-cycle window that follows
    task automatic step(input string tag, input logic [3:0] g);
        int nb;
        int d;
        logic [3:0] p;
        int ne;
        nb = g2b(g);
        d  = (nb - m_bin + 16) % 16;
        ne = m_errc;
        p  = 4'b0;
        if (d == 1) begin
            p = {1'b1, 1'b0, (m_bin == 15), 1'b0};
        end else if (d == 15) begin
            p = {1'b0, 1'b1, (m_bin == 0), 1'b0};
        end else if (d != 0) begin
            p  = 4'b0001;
            ne = (m_errc < 255) ? m_errc + 1 : 255;
        end
        gray_in = g;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j < 2)       chk_all({tag, ".pre"}, 1'b1, m_bin, 4'b0, m_errc);
            else if (j == 2) chk_all({tag, ".evt"}, 1'b1, nb, p, ne);
            else             chk_all({tag, ".post"}, 1'b1, nb, 4'b0, ne);
        end
        m_bin  = nb;
        m_errc = ne;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        gray_in  = '0;
        #1;
        chk_all("reset", 1'b0, 0, 4'b0, 0);

        // Acquire a non-zero code
        acquire("acq0110", 4'b0110);
        chk("acq.bin0100", 32'(bin_out), 32'b0100);

        // Full count-up cycle with one wrap
        acquire("up", 4'b0000);
        for (int i = 1; i <= 16; i++) begin
            step("up", b2g(i));
        end

        // Count down across the 0 boundary
        acquire("dn", 4'b0000);
        step("dn1000", 4'b1000);
        step("dn1001", 4'b1001);

        // Illegal jump then legal step down
        acquire("ill", 4'b0000);
        step("ill0001", 4'b0001);
        step("ill0111", 4'b0111);
        step("ill0110", 4'b0110);

        // Randomized mix of holds, steps and jumps
        acquire("rnd", b2g($urandom_range(0, 15)));
        for (int i = 0; i < 150; i++) begin
            int k;
            int nb;
            k = $urandom_range(0, 3);
            if (k == 0)      nb = m_bin + 1;
            else if (k == 1) nb = m_bin - 1 + 16;
            else if (k == 2) nb = $urandom_range(0, 15);
            else             nb = m_bin;
            step("rnd", b2g(nb));
        end

        // Saturation of err_count
        acquire("sat", 4'b0000);
        for (int i = 0; i < 260; i++) begin
            step("sat", (i % 2 == 0) ? 4'b0011 : 4'b0000);
        end
        chk("sat.final", 32'(err_count), 32'd255);

        // Asynchronous reset while tracking
        acquire("mid", 4'b0000);
        step("mid3", b2g(3));
        step("mid7", b2g(7));
        step("mid10", b2g(10));
        chk("mid.bin1010", 32'(bin_out), 32'b1010);
        chk("mid.errc3", 32'(err_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid.async", 1'b0, 0, 4'b0, 0);
        acquire("mid.re", b2g(6));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
